// File: rtl/sd_pkg.sv
// Shared definitions for the signed-digit on-the-fly converter:
// FSM state encoding and the (pos,neg) digit codes.
package sd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Digit codes as {dinp, dinn}; 2'b00 and 2'b11 both mean zero.
  localparam logic [1:0] SD_POS = 2'b10;
  localparam logic [1:0] SD_NEG = 2'b01;

endpackage : sd_pkg

// File: rtl/otf_step.sv
// One on-the-fly conversion step: appends a radix-2 signed digit to the
// register pair (Q, QM = Q-1) using shifts and selects only, so the
// result never needs a carry-propagate adder.
module otf_step
  import sd_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0] q_i,
  input  logic [W-1:0] qm_i,
  input  logic [1:0]   digit_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] qm_o
);

  // Select the shifted source and the appended bit for each digit value.
  always_comb begin
    // NOTE: every output gets a value before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    q_o  = (q_i  << 1);
    qm_o = (qm_i << 1) | W'(1);
    case (digit_i)
      SD_POS: begin
        q_o  = (q_i << 1) | W'(1);
        qm_o = (q_i << 1);
      end
      SD_NEG: begin
        q_o  = (qm_i << 1) | W'(1);
        qm_o = (qm_i << 1);
      end
      default: ;
    endcase
  end

endmodule : otf_step

// File: rtl/otf_converter.sv
// Serial MSB-first signed-digit to two's-complement converter.
// Accepts no_of_digits digits in ACCUM, then presents the result in DONE
// until the consumer takes it.
module otf_converter
  import sd_pkg::*;
#(
  parameter int no_of_digits = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  din_valid,
  input  logic                  dinp,
  input  logic                  dinn,
  output logic                  din_ready,
  output logic [no_of_digits:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy
);

  localparam int W  = no_of_digits + 1;
  localparam int CW = $clog2(no_of_digits + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(no_of_digits - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    q_q, q_d;
  logic [W-1:0]    qm_q, qm_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    q_step, qm_step;

  otf_step #(.W(W)) u_step (
    .q_i     (q_q),
    .qm_i    (qm_q),
    .digit_i ({dinp, dinn}),
    .q_o     (q_step),
    .qm_o    (qm_step)
  );

  // State, conversion registers and digit counter; reset wins over everything.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      // NOTE: Q/QM are reset too, so the QM = Q-1 invariant holds from the
      // first cycle even though IDLE reloads them on start.
      state_q <= ST_IDLE;
      q_q     <= '0;
      qm_q    <= '1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      qm_q    <= qm_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    qm_d       = qm_q;
    cnt_d      = cnt_q;
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    dout       = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCUM;
          q_d     = '0;
          qm_d    = '1;
          cnt_d   = '0;
        end
      end
      ST_ACCUM: begin
        din_ready = 1'b1;
        if (din_valid) begin
          q_d   = q_step;
          qm_d  = qm_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_IDX) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        dout_valid = 1'b1;
        dout       = q_q;
        if (dout_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

endmodule : otf_converter

// File: tb/tb_otf_converter.sv
// Scoreboard bench for otf_converter (no_of_digits = 8): the driver pushes
// expected results, a negedge monitor pops and compares on each handshake.
module tb_otf_converter;

  localparam int N = 8;
  localparam int W = N + 1;

  logic         clk = 1'b0;
  logic         rst, start, din_valid, dinp, dinn, dout_ready;
  logic         din_ready, dout_valid, busy;
  logic [W-1:0] dout;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  otf_converter #(.no_of_digits(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .din_valid  (din_valid),
    .dinp       (dinp),
    .dinn       (dinn),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Integer reference: sum of d_i * 2^(7-i), MSB digit first.
  function automatic logic [W-1:0] model(input logic [15:0] c);
    int v;
    logic [1:0] d;
    v = 0;
    for (int i = 0; i < N; i++) begin
      d = c[15-2*i -: 2];
      if (d == 2'b10) v += (1 << (N - 1 - i));
      else if (d == 2'b01) v -= (1 << (N - 1 - i));
    end
    return W'(v);
  endfunction

  // Monitor: compares on handshake, checks stability and idle outputs.
  logic         prev_valid = 1'b0;
  logic         prev_hs = 1'b0;
  logic [W-1:0] prev_dout = '0;

  always @(negedge clk) begin
    if (dout_valid) begin
      check("din_ready_in_done", din_ready, 0);
      if (prev_valid && !prev_hs) check("dout_stable", dout, prev_dout);
      if (dout_ready) begin
        check("scoreboard_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("dout_value", dout, exp_q.pop_front());
      end
    end else begin
      check("dout_zero_when_invalid", dout, 0);
    end
    prev_valid <= dout_valid;
    prev_hs    <= dout_valid && dout_ready;
    prev_dout  <= dout;
  end

  task automatic convert(input logic [15:0] codes, input logic [W-1:0] exp,
                         input bit gaps, input int hold, input bit start_in_accum);
    int g;
    bit gone;
    exp_q.push_back(exp);
    check("idle_before_start", busy, 0);
    start = 1'b1;
    tick();
    if (!start_in_accum) start = 1'b0;
    check("busy_in_accum", busy, 1);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) begin
          din_valid = 1'b0;
          {dinp, dinn} = 2'($urandom);
          tick();
        end
      end
      din_valid = 1'b1;
      {dinp, dinn} = codes[15-2*i -: 2];
      check("din_ready_accum", din_ready, 1);
      check("no_early_valid", dout_valid, 0);
      tick();
    end
    din_valid = 1'b0;
    {dinp, dinn} = 2'b00;
    start = 1'b0;
    check("latency_valid", dout_valid, 1);
    repeat (hold) tick();
    dout_ready = 1'b1;
    gone = 1'b0;
    for (int k = 0; k < 4 && !gone; k++) begin
      tick();
      if (!dout_valid) gone = 1'b1;
    end
    check("done_to_idle", gone, 1);
    check("busy_after_done", busy, 0);
    dout_ready = 1'b0;
  endtask

  task automatic abort_after(input int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      din_valid = 1'b1;
      {dinp, dinn} = 2'b10;
      tick();
    end
    din_valid = 1'b0;
    {dinp, dinn} = 2'b00;
    rst = 1'b1;
    start = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_din_ready", din_ready, 0);
    check("abort_dout_valid", dout_valid, 0);
    check("abort_dout", dout, 0);
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("rst_beats_start", busy, 0);
    tick();
    check("idle_after_abort", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] c;
    rst = 1'b1;
    start = 1'b0;
    din_valid = 1'b0;
    dinp = 1'b0;
    dinn = 1'b0;
    dout_ready = 1'b0;
    repeat (3) tick();
    check("reset_din_ready", din_ready, 0);
    check("reset_dout", dout, 0);
    check("reset_dout_valid", dout_valid, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    tick();

    convert(16'h8000, 9'h080, 1'b0, 0, 1'b0);  // +1, 7x0
    convert(16'h5555, 9'h101, 1'b0, 0, 1'b0);  // 8x(-1) = -255
    convert(16'hAAAA, 9'h0FF, 1'b0, 0, 1'b0);  // 8x(+1) = 255
    convert(16'h9555, 9'h001, 1'b0, 0, 1'b0);  // +1, 7x(-1)
    convert(16'h0F3C, 9'h000, 1'b0, 1, 1'b0);  // mixed 00/11 zeros
    convert(16'h9A5C, 9'h064, 1'b1, 5, 1'b0);  // gaps, ready held off 5
    abort_after(3);
    convert(16'h6AAA, 9'h1FF, 1'b1, 2, 1'b1);  // -1, 7x(+1), start held in ACCUM
    abort_after(8);
    convert(16'h8000, 9'h080, 1'b0, 0, 1'b0);

    for (int r = 0; r < 1000; r++) begin
      c = 16'($urandom);
      convert(c, model(c), $urandom_range(0, 3) == 0, $urandom_range(0, 2), 1'b0);
    end

    tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_otf_converter
